// File: rtl/vec_mul_sequencer_if.sv
// Operand/result bundle for vec_mul_sequencer.
// master: operand source + result consumer; slave: the sequencer.
//   in_valid/in_ready/a_vec/b_vec  operand handshake
//   out_valid/out_ready/out_vec/out_dot  result handshake
//   busy  sequencer is computing or holding a result
interface vec_mul_sequencer_if #(
    parameter int ELEM_W = 8,
    parameter int N_ELEM = 4
);
    localparam int DOT_W = 2 * ELEM_W + $clog2(N_ELEM);
    localparam int VEC_W = N_ELEM * ELEM_W;

    logic             in_valid;
    logic             in_ready;
    logic [VEC_W-1:0] a_vec;
    logic [VEC_W-1:0] b_vec;
    logic             out_valid;
    logic             out_ready;
    logic [VEC_W-1:0] out_vec;
    logic [DOT_W-1:0] out_dot;
    logic             busy;

    modport master (
        output in_valid, a_vec, b_vec, out_ready,
        input  in_ready, out_valid, out_vec, out_dot, busy
    );

    modport slave (
        input  in_valid, a_vec, b_vec, out_ready,
        output in_ready, out_valid, out_vec, out_dot, busy
    );
endinterface

// File: rtl/vec_mul_sequencer.sv
// Element-wise vector multiplier sharing one multiplier over N_ELEM lanes.
// Ports: clk, rst (sync, active-high), bus (slave side of vec_mul_sequencer_if).
module vec_mul_sequencer #(
    parameter int ELEM_W = 8,
    parameter int N_ELEM = 4
) (
    input logic              clk,
    input logic              rst,
    vec_mul_sequencer_if.slave bus
);
    localparam int DOT_W = 2 * ELEM_W + $clog2(N_ELEM);
    localparam int VEC_W = N_ELEM * ELEM_W;
    localparam int IDX_W = $clog2(N_ELEM);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] idx;
    logic [VEC_W-1:0] a_reg;
    logic [VEC_W-1:0] b_reg;
    logic [VEC_W-1:0] vec_reg;
    logic [DOT_W-1:0] dot_reg;

    logic [ELEM_W-1:0]   a_el;
    logic [ELEM_W-1:0]   b_el;
    logic [2*ELEM_W-1:0] prod;
    logic                last;

    assign a_el = a_reg[idx*ELEM_W +: ELEM_W];
    assign b_el = b_reg[idx*ELEM_W +: ELEM_W];
    assign prod = {{ELEM_W{1'b0}}, a_el} * {{ELEM_W{1'b0}}, b_el};
    assign last = (idx == IDX_W'(N_ELEM - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.in_valid) state_nx = MUL;
            MUL:     if (last) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs decode the state register only, so neither
    // ready nor valid can loop back through the partner's combinational logic.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        unique case (state)
            IDLE: bus.in_ready = 1'b1;
            MUL:  bus.busy     = 1'b1;
            DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
            end
            default: bus.in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            vec_reg <= '0;
            dot_reg <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg   <= bus.a_vec;
                        b_reg   <= bus.b_vec;
                        vec_reg <= '0;
                        dot_reg <= '0;
                        idx     <= '0;
                    end
                end
                MUL: begin
                    vec_reg[idx*ELEM_W +: ELEM_W] <= prod[ELEM_W-1:0];
                    dot_reg <= dot_reg + {{(DOT_W-2*ELEM_W){1'b0}}, prod};
                    idx     <= last ? '0 : idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.out_vec = vec_reg;
    assign bus.out_dot = dot_reg;
endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Bench for vec_mul_sequencer: countdown reference model, per-cycle compare,
// directed literal cases and a randomized operand/backpressure phase.
module tb_vec_mul_sequencer;
    localparam int EW  = 8;
    localparam int N   = 4;
    localparam int VW  = N * EW;
    localparam int DW  = 2 * EW + $clog2(N);
    localparam int N8  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vec_mul_sequencer_if #(.ELEM_W(EW), .N_ELEM(N)) bus ();
    vec_mul_sequencer #(.ELEM_W(EW), .N_ELEM(N)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    vec_mul_sequencer_if #(.ELEM_W(EW), .N_ELEM(N8)) bus8 ();
    vec_mul_sequencer #(.ELEM_W(EW), .N_ELEM(N8)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timeout at %0t", name, $time);
    endtask

    function automatic logic [VW-1:0] pack4(input int e0, input int e1,
                                            input int e2, input int e3);
        return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    endfunction

    // Reference: products computed with plain integer arithmetic.
    function automatic void calc(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                 output logic [VW-1:0] v, output logic [DW-1:0] d);
        int unsigned x, y, pr, sum;
        v   = '0;
        sum = 0;
        for (int i = 0; i < N; i++) begin
            x   = int'(a[i*EW +: EW]);
            y   = int'(b[i*EW +: EW]);
            pr  = x * y;
            v[i*EW +: EW] = 8'(pr % 256);
            sum += pr;
        end
        d = DW'(sum);
    endfunction

    // Model: an accepted operation occupies N compute cycles, then its result
    // is held until the consumer takes it; results are cleared on acceptance.
    bit            m_en = 0;
    int            m_left = 0;
    bit            m_done = 0;
    logic [VW-1:0] m_vec = '0;
    logic [VW-1:0] p_vec;
    logic [DW-1:0] m_dot = '0;
    logic [DW-1:0] p_dot;
    longint        cyc = 0;
    longint        acc_q[$];
    logic [DW-1:0] dot_q[$];

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_left = 0;
            m_done = 0;
            m_vec  = '0;
            m_dot  = '0;
        end else if (m_done) begin
            if (bus.out_ready) m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1;
                m_vec  = p_vec;
                m_dot  = p_dot;
            end
        end else if (bus.in_valid) begin
            calc(bus.a_vec, bus.b_vec, p_vec, p_dot);
            m_vec  = '0;
            m_dot  = '0;
            m_left = N;
            acc_q.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (m_en) begin
            check("in_ready", bus.in_ready, (m_left == 0 && !m_done));
            check("out_valid", bus.out_valid, m_done);
            check("busy", bus.busy, (m_left > 0 || m_done));
            if (m_left == 0) begin
                check("out_vec", bus.out_vec, m_vec);
                check("out_dot", bus.out_dot, m_dot);
            end
            if (bus.out_valid === 1'b1) dot_q.push_back(bus.out_dot);
        end
    end

    bit rnd = 0;

    task automatic tick();
        @(negedge clk);
        if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    // Returns just after the accepting edge, with inputs scrambled.
    task automatic send(input logic [VW-1:0] a, input logic [VW-1:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.a_vec    = a;
        bus.b_vec    = b;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) timeout("send");
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a_vec    = VW'($urandom);
        bus.b_vec    = VW'($urandom);
    endtask

    // Counts rising edges from acceptance until out_valid is seen.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.out_valid !== 1'b1 && n < 200);
        if (n >= 200) timeout("wait_valid");
    endtask

    int lat;

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.a_vec      = '0;
        bus.b_vec      = '0;
        bus.out_ready  = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.a_vec     = '0;
        bus8.b_vec     = '0;
        bus8.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        m_en = 1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_out_vec", bus.out_vec, 0);
        check("rst_out_dot", bus.out_dot, 0);

        // basic product and latency
        send(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
        wait_valid(lat);
        check("t1_latency", lat, 4);
        @(negedge clk);
        check("t1_vec", bus.out_vec, 32'h2015_0C05);
        check("t1_dot", bus.out_dot, 70);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;

        // lane truncation, then backpressure on the held result
        send(pack4(16, 255, 0, 1), pack4(16, 255, 9, 1));
        wait_valid(lat);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t3_valid", bus.out_valid, 1);
            check("t3_in_ready", bus.in_ready, 0);
            check("t2_vec", bus.out_vec, 32'h0100_0100);
            check("t2_dot", bus.out_dot, 65282);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t3_release_ready", bus.in_ready, 1);
        check("t3_release_valid", bus.out_valid, 0);
        bus.out_ready = 1'b0;

        // reset sampled at the second compute edge
        send(pack4(9, 9, 9, 9), pack4(9, 9, 9, 9));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t4_valid", bus.out_valid, 0);
        check("t4_busy", bus.busy, 0);
        check("t4_vec", bus.out_vec, 0);
        check("t4_dot", bus.out_dot, 0);
        check("t4_ready", bus.in_ready, 1);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_no_stale", bus.out_valid, 0);
        end

        // back-to-back with the consumer always ready
        bus.out_ready = 1'b1;
        dot_q.delete();
        acc_q.delete();
        send(32'h0101_0101, 32'h0101_0101);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_valid(lat);
        @(negedge clk);
        @(negedge clk);
        check("t5_n_results", dot_q.size(), 2);
        check("t5_dot0", dot_q[0], 4);
        check("t5_dot1", dot_q[1], 260100);
        check("t5_spacing", acc_q[1] - acc_q[0], 6);

        // randomized operands, gaps and consumer backpressure
        rnd = 1;
        for (int k = 0; k < 40; k++) begin
            send(VW'($urandom), VW'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end
        rnd = 0;
        bus.out_ready = 1'b1;
        repeat (12) tick();

        // eight-lane build at maximum operands
        check("t6_rst_ready", bus8.in_ready, 1);
        check("t6_rst_valid", bus8.out_valid, 0);
        bus8.in_valid  = 1'b1;
        bus8.a_vec     = '1;
        bus8.b_vec     = '1;
        bus8.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        bus8.a_vec    = '0;
        bus8.b_vec    = '0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (bus8.out_valid !== 1'b1 && lat < 50);
        if (lat >= 50) timeout("t6_wait");
        check("t6_latency", lat, 8);
        @(negedge clk);
        check("t6_dot", bus8.out_dot, 520200);
        check("t6_vec", bus8.out_vec, 64'h0101_0101_0101_0101);
        bus8.out_ready = 1'b1;
        @(negedge clk);
        check("t6_release", bus8.in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
